// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, address geometry and
// engine state encodings used by both the read and write engines.
package sdram_pkg;

  localparam int unsigned ROW_W     = 12;
  localparam int unsigned COL_W     = 9;
  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned BURST_LEN = 4;

  // {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  // A10 high selects all banks on PRECHARGE
  localparam logic [ADDR_W-1:0] ADDR_PRE_ALL = 12'h400;

  // First column of the final burst in a row
  localparam logic [COL_W-1:0] COL_LAST_BURST = COL_W'((1 << COL_W) - BURST_LEN);

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_REQ  = 5'b00010,
    S_ACT  = 5'b00100,
    S_WR   = 5'b01000,
    S_PRE  = 5'b10000
  } state_e;

  // Why the engine entered precharge; decides where it goes afterwards
  typedef enum logic [1:0] {
    PRE_DONE  = 2'd0,
    PRE_YIELD = 2'd1,
    PRE_ROW   = 2'd2
  } pre_kind_e;

endpackage

// File: rtl/sdram_wr_addr_gen.sv
// Row/column address counters for the write engine: column steps one burst at a
// time, row advances on request; flags the last burst of a row and of the run.
module sdram_wr_addr_gen
  import sdram_pkg::*;
#(
  parameter int unsigned LAST_ROW = 4095
) (
  input  logic              sclk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              burst_done_i,
  input  logic              row_adv_i,
  output logic              row_end_o,
  output logic              last_burst_o,
  output logic [ADDR_W-1:0] act_addr_o,
  output logic [ADDR_W-1:0] wr_addr_o
);

  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      row_q <= '0;
      col_q <= '0;
    end else if (clr_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      // column wraps to 0 naturally after the last burst of a row
      if (burst_done_i) col_q <= col_q + COL_W'(BURST_LEN);
      if (row_adv_i)    row_q <= row_q + ROW_W'(1);
    end
  end

  assign row_end_o    = (col_q == COL_LAST_BURST);
  assign last_burst_o = row_end_o && (row_q == ROW_W'(LAST_ROW));
  assign act_addr_o   = ADDR_W'(row_q);
  assign wr_addr_o    = ADDR_W'(col_q);

endmodule

// File: rtl/sdram_write.sv
// SDRAM write engine: on a trigger, streams the write FIFO into bank 0 as BL=4
// bursts row by row, yielding the bus to auto-refresh between bursts.
module sdram_write
  import sdram_pkg::*;
#(
  parameter int unsigned LAST_ROW  = 4095,
  parameter int unsigned T_RCD_CYC = 3,
  parameter int unsigned T_RP_CYC  = 3,
  parameter int unsigned T_WR_CYC  = 2
) (
  input  logic              sclk,
  input  logic              reset,
  input  logic              wr_trig,
  input  logic              wr_en,
  input  logic              ref_req,
  output logic              wr_req,
  output logic              flag_wr_end,
  output logic              wr_done,
  output logic [3:0]        wr_cmd,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        bank_addr,
  output logic [15:0]       wr_data,
  output logic              wfifo_rd_en,
  input  logic [7:0]        wfifo_rd_data
);

  localparam int unsigned TMR_W = 4;
  localparam int unsigned BC_W  = $clog2(BURST_LEN);
  localparam logic [TMR_W-1:0] ACT_LAST   = TMR_W'(T_RCD_CYC - 1);
  localparam logic [TMR_W-1:0] PRE_CMD    = TMR_W'(T_WR_CYC);
  localparam logic [TMR_W-1:0] PRE_LAST   = TMR_W'(T_WR_CYC + T_RP_CYC);
  localparam logic [BC_W-1:0]  BURST_LAST = BC_W'(BURST_LEN - 1);

  state_e            state_q, state_d;
  pre_kind_e         pre_kind_q, pre_kind_d;
  logic              busy_q, busy_d;
  logic [TMR_W-1:0]  act_cnt_q, act_cnt_d;
  logic [TMR_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              flag_end_q, flag_end_d;
  logic              done_q, done_d;

  logic              clr, burst_done, row_adv;
  logic              row_end, last_burst;
  logic [ADDR_W-1:0] act_addr, col_addr;

  sdram_wr_addr_gen #(.LAST_ROW(LAST_ROW)) u_addr_gen (
    .sclk         (sclk),
    .reset        (reset),
    .clr_i        (clr),
    .burst_done_i (burst_done),
    .row_adv_i    (row_adv),
    .row_end_o    (row_end),
    .last_burst_o (last_burst),
    .act_addr_o   (act_addr),
    .wr_addr_o    (col_addr)
  );

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pre_kind_q  <= PRE_DONE;
      busy_q      <= 1'b0;
      act_cnt_q   <= '0;
      pre_cnt_q   <= '0;
      burst_cnt_q <= '0;
      cmd_q       <= CMD_NOP;
      addr_q      <= '0;
      flag_end_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_kind_q  <= pre_kind_d;
      busy_q      <= busy_d;
      act_cnt_q   <= act_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      flag_end_q  <= flag_end_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pre_kind_d  = pre_kind_q;
    busy_d      = busy_q;
    act_cnt_d   = '0;
    pre_cnt_d   = '0;
    burst_cnt_d = '0;
    cmd_d       = CMD_NOP;
    addr_d      = addr_q;
    flag_end_d  = 1'b0;
    done_d      = 1'b0;
    clr         = 1'b0;
    burst_done  = 1'b0;
    row_adv     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wr_trig && !busy_q) begin
          busy_d  = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (wr_en) state_d = S_ACT;
      end
      S_ACT: begin
        act_cnt_d = act_cnt_q + TMR_W'(1);
        if (act_cnt_q == '0) begin
          cmd_d  = CMD_ACT;
          addr_d = act_addr;
        end
        if (act_cnt_q == ACT_LAST) begin
          act_cnt_d = '0;
          state_d   = S_WR;
        end
      end
      S_WR: begin
        burst_cnt_d = burst_cnt_q + BC_W'(1);
        if (burst_cnt_q == '0) begin
          cmd_d  = CMD_WR;
          addr_d = col_addr;
        end
        // bursts are never cut short: leave only at the final beat
        if (burst_cnt_q == BURST_LAST) begin
          burst_done = 1'b1;
          row_adv    = row_end && !last_burst;
          if (last_burst) begin
            pre_kind_d = PRE_DONE;
            state_d    = S_PRE;
          end else if (ref_req) begin
            pre_kind_d = PRE_YIELD;
            state_d    = S_PRE;
          end else if (row_end) begin
            pre_kind_d = PRE_ROW;
            state_d    = S_PRE;
          end
        end
      end
      S_PRE: begin
        pre_cnt_d = pre_cnt_q + TMR_W'(1);
        if (pre_cnt_q == PRE_CMD) begin
          cmd_d  = CMD_PRE;
          addr_d = ADDR_PRE_ALL;
        end
        if (pre_cnt_q == PRE_LAST) begin
          pre_cnt_d = '0;
          case (pre_kind_q)
            PRE_DONE: begin
              done_d     = 1'b1;
              flag_end_d = 1'b1;
              busy_d     = 1'b0;
              clr        = 1'b1;
              state_d    = S_IDLE;
            end
            PRE_YIELD: begin
              flag_end_d = 1'b1;
              state_d    = S_REQ;
            end
            default: state_d = S_ACT;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_req      = (state_q == S_REQ);
  assign wfifo_rd_en = (state_q == S_WR);
  assign wr_data     = {8'h00, wfifo_rd_data};
  assign bank_addr   = 2'b00;
  assign wr_cmd      = cmd_q;
  assign wr_addr     = addr_q;
  assign flag_wr_end = flag_end_q;
  assign wr_done     = done_q;

endmodule

// File: tb/tb_sdram_write.sv
// Randomised scoreboard bench for sdram_write: a run-level model lists the
// expected bus commands and end pulses; a monitor pops and checks them.
module tb_sdram_write;
  import sdram_pkg::*;

  localparam int unsigned LAST_ROW = 1;
  localparam int unsigned T_RCD    = 3;
  localparam int unsigned T_RP     = 3;
  localparam int unsigned T_WR     = 2;
  localparam int NBURST = (LAST_ROW + 1) * 128;
  localparam int NBYTES = NBURST * 4;

  logic        sclk, reset, wr_trig, wr_en, ref_req;
  logic        wr_req, flag_wr_end, wr_done, wfifo_rd_en;
  logic [3:0]  wr_cmd;
  logic [11:0] wr_addr;
  logic [1:0]  bank_addr;
  logic [15:0] wr_data;
  logic [7:0]  wfifo_rd_data;

  sdram_write #(.LAST_ROW(LAST_ROW), .T_RCD_CYC(T_RCD), .T_RP_CYC(T_RP), .T_WR_CYC(T_WR)) dut (
    .sclk(sclk), .reset(reset), .wr_trig(wr_trig), .wr_en(wr_en), .ref_req(ref_req),
    .wr_req(wr_req), .flag_wr_end(flag_wr_end), .wr_done(wr_done), .wr_cmd(wr_cmd),
    .wr_addr(wr_addr), .bank_addr(bank_addr), .wr_data(wr_data),
    .wfifo_rd_en(wfifo_rd_en), .wfifo_rd_data(wfifo_rd_data)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  typedef struct {
    bit          is_cmd;
    logic [3:0]  cmd;
    logic [11:0] addr;
    int          burst;
    logic [1:0]  ends;   // {flag_wr_end, wr_done}
  } ev_t;

  ev_t        ev_q[$];
  logic [7:0] bytes_a [NBYTES];
  bit         yield_at [NBURST];
  int n_tests = 0, n_fail = 0;
  int exp_yields;
  int flag_cnt, done_cnt, req_rises, rd_cnt, writes_seen;
  int beats_left, beat_i, cur_burst, cyc, last_beat_cyc;
  int rd_idx, gnt_wait, gnt_max;
  bit mon_en, req_prev, rd_s;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push_cmd(input logic [3:0] c, input logic [11:0] a, input int b);
    ev_t e;
    e.is_cmd = 1'b1; e.cmd = c; e.addr = a; e.burst = b; e.ends = 2'b00;
    ev_q.push_back(e);
  endtask

  task automatic push_end(input logic [1:0] en);
    ev_t e;
    e.is_cmd = 1'b0; e.cmd = CMD_NOP; e.addr = '0; e.burst = -1; e.ends = en;
    ev_q.push_back(e);
  endtask

  // Whole-run expectation: rows in order, 128 bursts each, yields where requested
  task automatic build_model();
    int n;
    ev_q.delete();
    exp_yields = 0;
    n = 0;
    push_cmd(CMD_ACT, 12'd0, -1);
    for (int r = 0; r <= int'(LAST_ROW); r++) begin
      for (int c = 0; c < 128; c++) begin
        push_cmd(CMD_WR, 12'(4 * c), n);
        if (r == int'(LAST_ROW) && c == 127) begin
          push_cmd(CMD_PRE, 12'h400, -1);
          push_end(2'b11);
        end else if (yield_at[n]) begin
          exp_yields++;
          push_cmd(CMD_PRE, 12'h400, -1);
          push_end(2'b10);
          push_cmd(CMD_ACT, (c == 127) ? 12'(r + 1) : 12'(r), -1);
        end else if (c == 127) begin
          push_cmd(CMD_PRE, 12'h400, -1);
          push_cmd(CMD_ACT, 12'(r + 1), -1);
        end
        n++;
      end
    end
  endtask

  task automatic prepare_run(input bit counting);
    for (int i = 0; i < NBYTES; i++)
      bytes_a[i] = counting ? 8'(i + 1) : 8'($urandom);
    build_model();
    flag_cnt = 0; done_cnt = 0; req_rises = 0; rd_cnt = 0; writes_seen = 0;
    beats_left = 0; beat_i = 0; cur_burst = 0; last_beat_cyc = 0;
    rd_idx = 0; req_prev = 1'b0; ref_req = 1'b0; mon_en = 1'b1;
  endtask

  task automatic pulse_trig();
    @(negedge sclk); wr_trig = 1'b1;
    @(negedge sclk); wr_trig = 1'b0;
  endtask

  task automatic wait_writes(input int target);
    for (int i = 0; i < 5000 && writes_seen < target; i++) @(negedge sclk);
    check("writes_reached", 32'(writes_seen >= target), 32'd1);
  endtask

  task automatic finish_run(input string tag);
    for (int i = 0; i < 6000 && done_cnt == 0; i++) @(negedge sclk);
    repeat (20) @(negedge sclk);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_flag_cnt"}, 32'(flag_cnt), 32'(exp_yields + 1));
    check({tag, "_req_rises"}, 32'(req_rises), 32'(exp_yields + 1));
    check({tag, "_rd_en_cnt"}, 32'(rd_cnt), 32'(NBYTES));
    check({tag, "_events_left"}, 32'(ev_q.size()), 32'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_cmd"}, 32'(wr_cmd), 32'(CMD_NOP));
    check({tag, "_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_req"}, 32'(wr_req), 32'd0);
    check({tag, "_flag"}, 32'(flag_wr_end), 32'd0);
    check({tag, "_done"}, 32'(wr_done), 32'd0);
    check({tag, "_rd_en"}, 32'(wfifo_rd_en), 32'd0);
  endtask

  // Write FIFO with one-cycle read latency
  initial begin
    forever begin
      @(negedge sclk);
      rd_s = wfifo_rd_en;
      @(posedge sclk);
      #1;
      if (rd_s) begin
        wfifo_rd_data = (rd_idx < NBYTES) ? bytes_a[rd_idx] : 8'($urandom);
        rd_idx++;
      end
    end
  end

  // Arbiter: grants a pending request after a random delay, for one cycle
  initial begin
    gnt_wait = 0;
    forever begin
      @(negedge sclk);
      if (wr_en) begin
        wr_en = 1'b0;
        gnt_wait = $urandom_range(gnt_max, 0);
      end else if (wr_req) begin
        if (gnt_wait == 0) wr_en = 1'b1;
        else gnt_wait--;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    cyc = 0;
    forever begin
      @(negedge sclk);
      cyc++;
      if (mon_en && reset) begin
        if (wr_req && !req_prev) req_rises++;
        req_prev = wr_req;
        if (wfifo_rd_en) rd_cnt++;
        if (wr_cmd != CMD_NOP) begin
          if (ev_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL cmd_unexpected: got cmd 0x%0h addr 0x%0h, expected nothing", wr_cmd, wr_addr);
          end else begin
            ev_t e;
            e = ev_q.pop_front();
            check("cmd_bank_addr", {14'd0, bank_addr, wr_cmd, wr_addr}, {14'd0, 2'b00, e.cmd, e.addr});
            if (wr_cmd == CMD_WR && e.burst >= 0) begin
              writes_seen++;
              beats_left = 4; beat_i = 0; cur_burst = e.burst;
              if (yield_at[e.burst]) ref_req = 1'b1;
            end
            if (wr_cmd == CMD_PRE)
              check("pre_after_last_beat", 32'(cyc - last_beat_cyc), 32'(T_WR + 1));
          end
        end
        if (beats_left > 0) begin
          check("wr_data_beat", 32'(wr_data), {24'd0, bytes_a[cur_burst * 4 + beat_i]});
          beat_i++;
          beats_left--;
          if (beats_left == 0) last_beat_cyc = cyc;
        end
        if (flag_wr_end || wr_done) begin
          if (ev_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL end_unexpected: got flag %0b done %0b, expected nothing", flag_wr_end, wr_done);
          end else begin
            ev_t e;
            e = ev_q.pop_front();
            check("end_pulse", 32'({flag_wr_end, wr_done}), 32'(e.ends));
          end
          if (flag_wr_end) begin flag_cnt++; ref_req = 1'b0; end
          if (wr_done) done_cnt++;
        end
      end
    end
  end

  initial begin
    reset = 1'b0; wr_trig = 1'b0; wr_en = 1'b0; ref_req = 1'b0;
    wfifo_rd_data = 8'h00; mon_en = 1'b0; gnt_max = 0;
    repeat (3) @(negedge sclk);
    check_reset_outs("por");
    reset = 1'b1;
    repeat (2) @(negedge sclk);

    // Counting data, immediate grant, no refresh; a stray trigger mid-run
    for (int i = 0; i < NBURST; i++) yield_at[i] = 1'b0;
    gnt_max = 0;
    prepare_run(1'b1);
    pulse_trig();
    wait_writes(10);
    pulse_trig();
    finish_run("run0");

    // Refresh at col 64, at row end, and on the final burst
    for (int i = 0; i < NBURST; i++) yield_at[i] = 1'b0;
    yield_at[16] = 1'b1; yield_at[127] = 1'b1; yield_at[NBURST - 1] = 1'b1;
    gnt_max = 3;
    prepare_run(1'b0);
    pulse_trig();
    finish_run("run1");

    // Random refresh pattern and grant latency
    for (int i = 0; i < NBURST; i++) yield_at[i] = ($urandom_range(15, 0) == 0);
    gnt_max = 5;
    prepare_run(1'b0);
    pulse_trig();
    finish_run("run2");

    // Reset in the middle of a write burst
    for (int i = 0; i < NBURST; i++) yield_at[i] = 1'b0;
    gnt_max = 1;
    prepare_run(1'b0);
    pulse_trig();
    wait_writes(40);
    check("abort_in_wr_rd_en", 32'(wfifo_rd_en), 32'd1);
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_outs("midrst");
    repeat (3) @(negedge sclk);
    ref_req = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge sclk);

    // Fresh run after the abort starts again at row 0, col 0
    for (int i = 0; i < NBURST; i++) yield_at[i] = ($urandom_range(31, 0) == 0);
    gnt_max = 2;
    prepare_run(1'b0);
    pulse_trig();
    finish_run("run4");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_write.md
Name: sdram_write

Overview:
- Write-side engine of the SDRAM controller. It is the counterpart of the read engine and uses the same arbiter handshake.
- On `wr_trig`, it drains 8-bit bytes from the write FIFO. It stores them as 16-bit words (zero-extended), sequentially through bank 0, in BL=4 bursts.
- Between bursts it yields to auto-refresh through the arbiter.
- Its command, address and data outputs are muxed by the arbiter onto the SDRAM pins.

Parameters:
- `LAST_ROW`, 4095, last row written; the run covers rows 0..`LAST_ROW`, all 512 columns each.
- `T_RCD_CYC`, 3, cycles spent in ACT (ACT command plus NOPs) before the first WRITE.
- `T_RP_CYC`, 3, cycles after the PRECHARGE command before S_PRE may exit.
- `T_WR_CYC`, 2, NOP cycles after the last data beat before the PRECHARGE command.

Ports:
- `sclk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `wr_trig`  in  1  start a full write run (single-cycle pulse)
- `wr_en`  in  1  arbiter grant
- `ref_req`  in  1  refresh pending, from the refresh engine
- `wr_req`  out  1  bus request to the arbiter
- `flag_wr_end`  out  1  one-cycle pulse: bus released to the arbiter
- `wr_done`  out  1  one-cycle pulse: whole run complete
- `wr_cmd`  out  4  {CS_n,RAS_n,CAS_n,WE_n}
- `wr_addr`  out  12  SDRAM A[11:0]
- `bank_addr`  out  2  constant 2'b00
- `wr_data`  out  16  DQ write data
- `wfifo_rd_en`  out  1  write-FIFO read strobe
- `wfifo_rd_data`  in  8  write-FIFO data; read latency is exactly 1 cycle

Behaviour:
- Reset (async, active-low): all outputs are reset to:
  - `wr_cmd` = NOP (0111)
  - `wr_addr` = 0
  - `wr_req` = 0
  - `flag_wr_end` = 0
  - `wr_done` = 0
  - `wfifo_rd_en` = 0
- Reset state: row/column counters 0, state S_IDLE, busy flag clear. A reset mid-burst abandons the run with no PRECHARGE; the init block re-precharges.
- Commands: NOP 0111, ACT 0011, WRITE 0100, PRE 0010. `wr_cmd` and `wr_addr` are registered, so they appear one cycle after the state/counter that produces them.
- States: S_IDLE, S_REQ, S_ACT, S_WR, S_PRE (one-hot, 5 bits).
- S_IDLE: on `wr_trig`, set busy and go to S_REQ. `wr_trig` is ignored while busy.
- S_REQ: `wr_req` = 1 (combinational from state). On `wr_en`, go to S_ACT.
- S_ACT:
  - `act_cnt` counts from 0. At `act_cnt`==0 the bus gets ACT with `wr_addr`=row.
  - After `T_RCD_CYC` cycles, go to S_WR.
- S_WR:
  - `burst_cnt` counts 0..3, wrapping.
  - At `burst_cnt`==0 the bus gets WRITE with `wr_addr`={3'b000, col[8:0]}; A10=0, no auto-precharge.
  - `wfifo_rd_en` = (state==S_WR), combinational. FIFO latency 1 aligns each byte with the registered command/beat.
  - `wr_data` = {8'h00, `wfifo_rd_data`}.
  - Column advances by 4 after each burst.
  - At `burst_cnt`==3, the next transition is chosen in priority order:
    - last burst of `LAST_ROW` → S_PRE (done)
    - `ref_req` → S_PRE (yield)
    - column 508 burst (row end) → S_PRE (row change)
    - else stay (back-to-back bursts)
  - A burst is never truncated.
- S_PRE:
  - `pre_cnt` counts from 0. At `pre_cnt`==`T_WR_CYC`, the bus gets PRE with A10=1 (all banks).
  - Exit after a further `T_RP_CYC` cycles:
    - done: `wr_done` and `flag_wr_end` pulse, clear busy, go to S_IDLE, reset counters to 0.
    - yield: `flag_wr_end` pulses, go to S_REQ; address is retained and resumes at the next column.
    - row change: row+1, column 0, go to S_ACT without releasing the bus.
- `ref_req` arriving simultaneously with row end or done: done takes precedence, then yield. On yield, the row increment still happens before S_REQ.
- Address counter widths: column 9 bits, row 12 bits.

Decomposition:
- Shared package `sdram_pkg`: CMD_NOP/ACT/WR/PRE/AREF constants, state encodings, ROW_W=12, COL_W=9, BURST_LEN=4. The read engine uses the same package.
- One natural sub-module: `sdram_wr_addr_gen`. It holds the row/column counters and produces the row_end, last_burst and next-address outputs, controlled by burst-done and row-advance strobes.

Test Plan:
- `LAST_ROW`=0, grant immediately, no refresh:
  - ACT row 0, then 128 WRITEs cols 0,4,…,508, back-to-back every 4 cycles.
  - PRE with A10=1 exactly `T_WR_CYC`+1 cycles after the last beat.
  - `wr_done` and `flag_wr_end` pulse once.
- FIFO preloaded 0x01..0x10: `wr_data` beats 0x0001..0x0010 coincide with the WRITE command cycle and the 3 following cycles. `wfifo_rd_en` count equals 16 after 4 bursts.
- `ref_req` raised at `burst_cnt`==1 of the col-64 burst:
  - The burst completes, PRE follows, `flag_wr_end` pulses, state is S_REQ.
  - After `wr_en`, ACT same row, first WRITE col 68.
- `LAST_ROW`=1: after the col-508 burst of row 0, PRE then ACT row 1 with no `flag_wr_end` and `wr_req` low throughout.
- `wr_trig` re-pulsed mid-run: ignored; exactly one `wr_done`.
- Reset asserted during S_WR: outputs at reset values immediately. A new `wr_trig` restarts at row 0, col 0.
